// File: rtl/eq_coeff_load_ctrl.sv
// Equaliser coefficient load sequencer: turns software register commits into single
// shadow-bank RAM writes and swaps active/shadow banks on frame sync.
module eq_coeff_load_ctrl #(
  parameter int ADDR_W  = 10,
  parameter int COEFF_W = 16,
  parameter int SETTLE  = 2
) (
  input  logic               user_clk,
  input  logic               user_rst_n,
  input  logic [31:0]        addr_reg_in,
  input  logic [31:0]        data_reg_in,
  input  logic               sync_in,
  input  logic [ADDR_W-1:0]  chan_in,
  output logic               ram_we,
  output logic [ADDR_W:0]    ram_waddr,
  output logic [COEFF_W-1:0] ram_wdata,
  output logic [ADDR_W:0]    ram_raddr,
  output logic               active_bank,
  output logic               swap_pending,
  output logic               busy,
  output logic [15:0]        write_count
);

  localparam int CNT_W = 4;

  typedef enum logic [1:0] {S_INIT, S_IDLE, S_SETTLE, S_WRITE} state_t;

  typedef struct packed {
    logic               bank;
    logic               swap;
    logic [ADDR_W-1:0]  chan;
    logic [COEFF_W-1:0] coeff;
  } cmd_t;

  state_t           state, state_nxt;
  cmd_t             cmd_q;
  logic             prev_tog;
  logic [CNT_W-1:0] cnt;
  logic             commit, capture, do_swap, bank_nxt;
  logic             unused_bits;

  assign commit   = (state == S_IDLE) && (addr_reg_in[31] != prev_tog);
  assign capture  = (state == S_SETTLE) && (cnt == '0);
  assign do_swap  = sync_in && swap_pending;
  assign bank_nxt = active_bank ^ do_swap;

  assign ram_waddr   = {cmd_q.bank, cmd_q.chan};
  assign ram_wdata   = cmd_q.coeff;
  assign unused_bits = ^{addr_reg_in[29:ADDR_W], data_reg_in[31:COEFF_W]};

  always_ff @(posedge user_clk or negedge user_rst_n) begin
    if (!user_rst_n) state <= S_INIT;
    else             state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      S_INIT:   state_nxt = S_IDLE;
      S_IDLE:   if (commit)  state_nxt = S_SETTLE;
      S_SETTLE: if (capture) state_nxt = S_WRITE;
      S_WRITE:  state_nxt = S_IDLE;
      default:  state_nxt = S_INIT;
    endcase
  end

  // INIT is the reset state; it reports not-busy so every output is 0 while in reset.
  always_comb begin
    ram_we = 1'b0;
    busy   = 1'b0;
    unique case (state)
      S_SETTLE: busy = 1'b1;
      S_WRITE:  begin ram_we = 1'b1; busy = 1'b1; end
      default:  ;
    endcase
  end

  always_ff @(posedge user_clk or negedge user_rst_n) begin
    if (!user_rst_n) begin
      prev_tog <= 1'b0;
      cnt      <= '0;
      cmd_q    <= '0;
    end else begin
      if (state == S_INIT || commit) prev_tog <= addr_reg_in[31];
      if (commit)
        cnt <= CNT_W'(SETTLE - 1);
      else if (state == S_SETTLE && cnt != '0)
        cnt <= cnt - CNT_W'(1);
      // Target the bank that will be shadow during WRITE, even if a sync flips it this edge.
      if (capture) begin
        cmd_q.bank  <= ~bank_nxt;
        cmd_q.swap  <= addr_reg_in[30];
        cmd_q.chan  <= addr_reg_in[ADDR_W-1:0];
        cmd_q.coeff <= data_reg_in[COEFF_W-1:0];
      end
    end
  end

  always_ff @(posedge user_clk or negedge user_rst_n) begin
    if (!user_rst_n) begin
      write_count  <= '0;
      active_bank  <= 1'b0;
      swap_pending <= 1'b0;
      ram_raddr    <= '0;
    end else begin
      if (ram_we) write_count <= write_count + 16'd1;
      if (do_swap) active_bank <= ~active_bank;
      // A swap armed in WRITE survives a coincident sync and waits for the next one.
      swap_pending <= (swap_pending & ~sync_in) | (ram_we & cmd_q.swap);
      ram_raddr    <= {active_bank, chan_in};
    end
  end

endmodule

// File: tb/tb_eq_coeff_load_ctrl.sv
// Scoreboard bench for eq_coeff_load_ctrl: directed cases plus randomized commits/syncs
// against a cycle-indexed reference model.
module tb_eq_coeff_load_ctrl;
  localparam int ADDR_W  = 10;
  localparam int COEFF_W = 16;
  localparam int SETTLE  = 2;

  logic               user_clk = 1'b0;
  logic               user_rst_n = 1'b0;
  logic [31:0]        addr_reg_in = '0;
  logic [31:0]        data_reg_in = '0;
  logic               sync_in = 1'b0;
  logic [ADDR_W-1:0]  chan_in = '0;
  logic               ram_we;
  logic [ADDR_W:0]    ram_waddr;
  logic [COEFF_W-1:0] ram_wdata;
  logic [ADDR_W:0]    ram_raddr;
  logic               active_bank, swap_pending, busy;
  logic [15:0]        write_count;

  eq_coeff_load_ctrl #(.ADDR_W(ADDR_W), .COEFF_W(COEFF_W), .SETTLE(SETTLE)) dut (
    .user_clk(user_clk), .user_rst_n(user_rst_n),
    .addr_reg_in(addr_reg_in), .data_reg_in(data_reg_in),
    .sync_in(sync_in), .chan_in(chan_in),
    .ram_we(ram_we), .ram_waddr(ram_waddr), .ram_wdata(ram_wdata),
    .ram_raddr(ram_raddr), .active_bank(active_bank), .swap_pending(swap_pending),
    .busy(busy), .write_count(write_count)
  );

  always #5 user_clk = ~user_clk;

  int cyc = 0;
  always @(posedge user_clk) cyc <= cyc + 1;

  typedef struct {
    int                 cyc;
    logic [ADDR_W:0]    waddr;
    logic [COEFF_W-1:0] wdata;
    logic [15:0]        cnt;
  } wr_exp_t;

  typedef struct {
    int              cyc;
    logic            bank;
    logic            pend;
    logic            busy;
    logic [ADDR_W:0] raddr;
    logic [15:0]     cnt;
  } st_exp_t;

  wr_exp_t wq[$];
  st_exp_t sq[$];
  int n_chk = 0;
  int n_fail = 0;

  function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endfunction

  // Reference model: commit/settle/write expressed as cycle arithmetic.
  logic              m_init = 1'b1;
  logic              m_prev = 1'b0;
  int                m_idle_from = 0;
  int                m_cap = -1;
  int                m_wcyc = -1;
  logic              m_bank = 1'b0;
  logic              m_pend = 1'b0;
  logic [15:0]       m_cnt = '0;
  logic [ADDR_W-1:0] m_chan = '0;
  logic [15:0]       m_coeff = '0;
  logic              m_swap = 1'b0;

  task automatic step(input logic [31:0] a, input logic [31:0] d, input logic s,
                      input logic [ADDR_W-1:0] ch);
    int   k;
    logic bank_k;
    @(negedge user_clk);
    user_rst_n = 1'b1;
    addr_reg_in = a; data_reg_in = d; sync_in = s; chan_in = ch;
    k = cyc;
    bank_k = m_bank;
    if (m_init) begin
      m_prev = a[31]; m_idle_from = k + 1; m_init = 1'b0;
    end else if (k >= m_idle_from && a[31] != m_prev) begin
      m_prev = a[31]; m_cap = k + SETTLE; m_idle_from = k + SETTLE + 2;
    end
    if (k == m_cap) begin
      m_chan = a[ADDR_W-1:0]; m_coeff = d[15:0]; m_swap = a[30];
    end
    if (s && m_pend) begin m_bank = ~m_bank; m_pend = 1'b0; end
    if (k == m_wcyc) begin
      if (m_swap) m_pend = 1'b1;
      m_cnt = m_cnt + 16'd1;
    end
    if (k == m_cap) begin
      m_wcyc = k + 1;
      wq.push_back(wr_exp_t'{k + 1, {~m_bank, m_chan}, m_coeff, m_cnt});
    end
    sq.push_back(st_exp_t'{k + 1, m_bank, m_pend, (k + 1 < m_idle_from), {bank_k, ch}, m_cnt});
  endtask

  task automatic apply_reset(input int hold, input logic [31:0] a);
    @(negedge user_clk);
    #2;
    user_rst_n = 1'b0;
    addr_reg_in = a;
    #1;
    chk("rst_we", ram_we, 0);
    chk("rst_waddr", ram_waddr, 0);
    chk("rst_wdata", ram_wdata, 0);
    chk("rst_raddr", ram_raddr, 0);
    chk("rst_bank", active_bank, 0);
    chk("rst_pend", swap_pending, 0);
    chk("rst_busy", busy, 0);
    chk("rst_count", write_count, 0);
    wq.delete(); sq.delete();
    m_init = 1'b1; m_bank = 1'b0; m_pend = 1'b0; m_cnt = '0;
    m_idle_from = 0; m_cap = -1; m_wcyc = -1;
    repeat (hold) @(negedge user_clk);
  endtask

  always @(negedge user_clk) begin
    wr_exp_t e;
    st_exp_t s;
    if (user_rst_n) begin
      while (wq.size() > 0 && wq[0].cyc < cyc) begin
        chk("write_cycle", cyc, wq[0].cyc);
        e = wq.pop_front();
      end
      if (ram_we) begin
        if (wq.size() == 0) chk("unexpected_we", ram_we, 0);
        else begin
          e = wq.pop_front();
          chk("write_cycle", cyc, e.cyc);
          chk("waddr", ram_waddr, e.waddr);
          chk("wdata", ram_wdata, e.wdata);
          chk("count_at_write", write_count, e.cnt);
        end
      end
      while (sq.size() > 0 && sq[0].cyc < cyc) s = sq.pop_front();
      if (sq.size() > 0 && sq[0].cyc == cyc) begin
        s = sq.pop_front();
        chk("active_bank", active_bank, s.bank);
        chk("swap_pending", swap_pending, s.pend);
        chk("busy", busy, s.busy);
        chk("raddr", ram_raddr, s.raddr);
        chk("write_count", write_count, s.cnt);
      end
    end
  end

  initial begin
    logic [31:0] a;
    logic        tog;

    // 1: toggle high across reset is not a commit
    apply_reset(3, 32'h8000_0000);
    for (int i = 0; i < 20; i++) step(32'h8000_0000, $urandom, 1'b0, ADDR_W'($urandom));
    chk("t1_count", write_count, 0);

    // 2: first commit, SETTLE+1 cycles later
    apply_reset(2, 32'h0);
    repeat (3) step(32'h0, 32'h0, 1'b0, '0);
    step(32'h8000_0005, 32'h1234, 1'b0, '0);
    repeat (3) step(32'h8000_0005, 32'h1234, 1'b0, '0);
    chk("t2_we", ram_we, 1);
    chk("t2_waddr", ram_waddr, 32'h405);
    chk("t2_wdata", ram_wdata, 32'h1234);
    step(32'h8000_0005, 32'h1234, 1'b0, '0);
    chk("t2_we_low", ram_we, 0);
    chk("t2_count", write_count, 1);

    // 3: swap armed, flips on next sync, read address follows
    step(32'h4000_03FF, 32'hBEEF, 1'b0, '0);
    repeat (3) step(32'h4000_03FF, 32'hBEEF, 1'b0, '0);
    chk("t3_we", ram_we, 1);
    chk("t3_waddr", ram_waddr, 32'h7FF);
    chk("t3_wdata", ram_wdata, 32'hBEEF);
    step(32'h4000_03FF, 32'hBEEF, 1'b0, '0);
    chk("t3_pend", swap_pending, 1);
    chk("t3_bank_before", active_bank, 0);
    step(32'h4000_03FF, 32'hBEEF, 1'b1, '0);
    step(32'h4000_03FF, 32'hBEEF, 1'b0, 10'd3);
    chk("t3_bank", active_bank, 1);
    chk("t3_pend_clr", swap_pending, 0);
    step(32'h4000_03FF, 32'hBEEF, 1'b0, '0);
    chk("t3_raddr", ram_raddr, 32'h403);

    // 4: WRITE coincident with sync defers the swap
    step(32'hC000_0010, 32'h5A5A, 1'b0, '0);
    repeat (2) step(32'hC000_0010, 32'h5A5A, 1'b0, '0);
    step(32'hC000_0010, 32'h5A5A, 1'b1, '0);
    chk("t4_we", ram_we, 1);
    chk("t4_waddr", ram_waddr, 32'h010);
    step(32'hC000_0010, 32'h5A5A, 1'b0, '0);
    chk("t4_bank_hold", active_bank, 1);
    chk("t4_pend", swap_pending, 1);
    step(32'hC000_0010, 32'h5A5A, 1'b1, '0);
    step(32'hC000_0010, 32'h5A5A, 1'b0, '0);
    chk("t4_bank_flip", active_bank, 0);
    chk("t4_pend_clr", swap_pending, 0);

    // 5: two extra toggles while busy are lost
    step(32'h0000_0020, 32'h1111, 1'b0, '0);
    step(32'h8000_0021, 32'h1111, 1'b0, '0);
    step(32'h0000_0022, 32'h2222, 1'b0, '0);
    step(32'h0000_0022, 32'h2222, 1'b0, '0);
    chk("t5_we", ram_we, 1);
    chk("t5_waddr", ram_waddr, 32'h422);
    chk("t5_wdata", ram_wdata, 32'h2222);
    repeat (8) step(32'h0000_0022, 32'h2222, 1'b0, '0);
    chk("t5_count", write_count, 4);

    // random commits, swaps and syncs
    tog = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 5) == 0) tog = ~tog;
      a = $urandom;
      a[31] = tog;
      a[30] = ($urandom_range(0, 2) == 0);
      step(a, $urandom, ($urandom_range(0, 7) == 0), ADDR_W'($urandom));
    end
    repeat (10) step({tog, 31'h0}, 32'h0, 1'b0, '0);

    // 6: reset during SETTLE abandons the write
    step({~tog, 31'h7}, 32'h7777, 1'b0, '0);
    step({~tog, 31'h7}, 32'h7777, 1'b0, '0);
    apply_reset(2, {~tog, 31'h7});
    for (int i = 0; i < 10; i++) step({~tog, 31'h7}, 32'h7777, 1'b0, ADDR_W'(i));
    chk("t6_count", write_count, 0);
    chk("t6_bank", active_bank, 0);

    chk("pending_writes", wq.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
